busca_quadrante_param: RTL and testbench

//  Parametrised nearest-target search over the occupancy grid: from (pos_x,pos_y), scans one selectable

---
 rtl/busca_quadrante_param.sv | 188 ++++++++++++++++++
 tb/tb_busca_quadrante_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/busca_quadrante_param.sv
// busca_quadrante_param: nearest-target search over the occupancy grid.
// Scans one quadrant around (pos_x,pos_y) in square rings of growing radius,
// one cell per cycle through a 1-cycle-latency memory port, and reports the
// Manhattan-closest cell equal to ValorAlvo found in the first ring that has one.
// Optional feature macro: BUSCA_ESTATISTICA_EN adds the celulas_lidas read counter.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing the cells of the current ring, one per cycle
// DRAIN | last read of the ring is being compared
// EVAL  | decide: finish, or move on to the next ring
// DONE  | one-cycle done pulse
module busca_quadrante_param #(
  parameter int         TamanhoMalha     = 20,
  parameter int         tamanhoDistancia = 8,
  parameter logic [1:0] ValorAlvo        = 2'd3,
  parameter int         RaioMax          = TamanhoMalha - 1,
  parameter int         AW               = $clog2(TamanhoMalha * TamanhoMalha)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [1:0]                  quadrante,
  input  logic [tamanhoDistancia-1:0] pos_x,
  input  logic [tamanhoDistancia-1:0] pos_y,
  output logic                        mem_rd,
  output logic [AW-1:0]               mem_addr,
  input  logic [1:0]                  mem_data,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [tamanhoDistancia-1:0] best_dist,
  output logic [tamanhoDistancia-1:0] best_x,
  output logic [tamanhoDistancia-1:0] best_y,
  output logic [tamanhoDistancia-1:0] raio_atual
`ifdef BUSCA_ESTATISTICA_EN
  ,
  output logic [15:0]                 celulas_lidas
`endif
);

  localparam int W  = tamanhoDistancia;
  // two extra bits: one for the sign of x-dx / y-dy, one for the carry of x+dx
  localparam int CW = W + 2;
  localparam logic [W-1:0]  UM         = 1;
  localparam logic [W-1:0]  RAIO_MAX_W = W'(RaioMax);
  localparam logic [CW-1:0] LADO_C     = CW'(TamanhoMalha);

  // the "no result yet" value (all ones) must stay above every reachable distance
  if (2 * RaioMax >= (1 << tamanhoDistancia) - 1) begin : g_raio_chk
    $error("busca_quadrante_param: 2*RaioMax does not fit tamanhoDistancia");
  end

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_EVAL, S_DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]    quad;
  logic [W-1:0]  ox, oy, dx, dy;
  logic          ring_any_in;
  logic          cmp_valid;
  logic [W-1:0]  cmp_dist, cmp_x, cmp_y;
  logic [CW-1:0] cx, cy;
  logic          in_grid, ring_end, hit;
  logic [AW-1:0] addr_calc;

  // current cell coordinates, grid bounds test and compare-stage hit
  always_comb begin
    cx        = quad[0] ? ({2'b00, ox} + {2'b00, dx}) : ({2'b00, ox} - {2'b00, dx});
    cy        = quad[1] ? ({2'b00, oy} - {2'b00, dy}) : ({2'b00, oy} + {2'b00, dy});
    in_grid   = !cx[CW-1] && !cy[CW-1] && (cx < LADO_C) && (cy < LADO_C);
    addr_calc = AW'(32'(cy[W-1:0]) * 32'(TamanhoMalha) + 32'(cx[W-1:0]));
    // radius is at least 1, so dy reaches 0 only at the bottom of the dx=r column
    ring_end  = (dy == '0);
    hit       = cmp_valid && (mem_data == ValorAlvo) && (cmp_dist < best_dist);
  end

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; abort wins over everything outside IDLE
  always_comb begin
    state_nxt = state;
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start && !abort) state_nxt = S_SCAN;
        S_SCAN:  if (ring_end) state_nxt = S_DRAIN;
        S_DRAIN: state_nxt = S_EVAL;
        S_EVAL:  if (found || raio_atual == RAIO_MAX_W || !ring_any_in) state_nxt = S_DONE;
                 else state_nxt = S_SCAN;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // outputs decoded from state; out-of-grid cells cost a cycle but no read
  always_comb begin
    mem_rd   = (state == S_SCAN) && in_grid && !abort;
    mem_addr = mem_rd ? addr_calc : '0;
    busy     = (state == S_SCAN) || (state == S_DRAIN) || (state == S_EVAL);
    done     = (state == S_DONE);
  end

  // datapath: request latch, ring walk, compare stage and best-result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quad        <= '0;
      ox          <= '0;
      oy          <= '0;
      dx          <= '0;
      dy          <= '0;
      ring_any_in <= 1'b0;
      cmp_valid   <= 1'b0;
      cmp_dist    <= '0;
      cmp_x       <= '0;
      cmp_y       <= '0;
      found       <= 1'b0;
      best_dist   <= '0;
      best_x      <= '0;
      best_y      <= '0;
      raio_atual  <= '0;
    end else begin
      cmp_valid <= mem_rd;
      cmp_dist  <= dx + dy;
      cmp_x     <= cx[W-1:0];
      cmp_y     <= cy[W-1:0];
      // strict compare keeps the first cell in scan order on ties
      if (hit) begin
        best_dist <= cmp_dist;
        best_x    <= cmp_x;
        best_y    <= cmp_y;
        found     <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            quad        <= quadrante;
            ox          <= pos_x;
            oy          <= pos_y;
            best_dist   <= '1;
            found       <= 1'b0;
            raio_atual  <= UM;
            dx          <= '0;
            dy          <= UM;
            ring_any_in <= 1'b0;
          end
        end
        S_SCAN: begin
          if (!abort) begin
            if (mem_rd) ring_any_in <= 1'b1;
            // top row dy=r left to right, then column dx=r downwards
            if (dy == raio_atual && dx < raio_atual) dx <= dx + UM;
            else if (dy != '0)                      dy <= dy - UM;
          end
        end
        S_EVAL: begin
          if (state_nxt == S_SCAN) begin
            raio_atual  <= raio_atual + UM;
            dx          <= '0;
            dy          <= raio_atual + UM;
            ring_any_in <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BUSCA_ESTATISTICA_EN
  // read-strobe counter for the current search, saturating
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      celulas_lidas <= '0;
    end else if (state == S_IDLE && start && !abort) begin
      celulas_lidas <= '0;
    end else if (mem_rd && celulas_lidas != 16'hFFFF) begin
      celulas_lidas <= celulas_lidas + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_busca_quadrante_param.sv
// Bench for busca_quadrante_param: 20x20 grid model with 1-cycle read latency,
// directed searches with hand-computed results.
module tb_busca_quadrante_param;
  localparam int N = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] quadrante = 2'd0;
  logic [7:0] pos_x = 8'd0;
  logic [7:0] pos_y = 8'd0;
  logic       mem_rd;
  logic [8:0] mem_addr;
  logic [1:0] mem_data = 2'd0;
  logic       busy, done, found;
  logic [7:0] best_dist, best_x, best_y, raio_atual;
`ifdef BUSCA_ESTATISTICA_EN
  logic [15:0] celulas_lidas;
`endif

  logic [1:0] grid [0:N*N-1];
  int n_chk = 0;
  int n_fail = 0;
  int rd_count = 0;
  int bad_addr = 0;
  int done_seen = 0;
  int rd_base, cyc, ds;

  busca_quadrante_param dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .quadrante(quadrante), .pos_x(pos_x), .pos_y(pos_y),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .found(found),
    .best_dist(best_dist), .best_x(best_x), .best_y(best_y),
    .raio_atual(raio_atual)
`ifdef BUSCA_ESTATISTICA_EN
    , .celulas_lidas(celulas_lidas)
`endif
  );

  always #5 clock = ~clock;

  // grid RAM model: data one cycle after the strobe
  always @(posedge clock) begin
    if (mem_rd && mem_addr < 9'd400) mem_data <= grid[mem_addr];
  end

  // monitors sampled on the falling edge
  always @(negedge clock) begin
    if (mem_rd) begin
      rd_count++;
      if (mem_addr >= 9'd400) bad_addr++;
    end
    if (done) done_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_grid();
    for (int i = 0; i < N*N; i++) grid[i] = 2'd0;
  endtask

  task automatic put(input int x, input int y, input logic [1:0] v);
    grid[y*N + x] = v;
  endtask

  // start presented for one cycle; inputs scrambled afterwards to prove latching
  task automatic do_start(input logic [7:0] px, input logic [7:0] py, input logic [1:0] q);
    @(negedge clock);
    pos_x = px; pos_y = py; quadrante = q; start = 1'b1;
    rd_base = rd_count;
    @(negedge clock);
    start = 1'b0; pos_x = 8'hAA; pos_y = 8'h55; quadrante = ~q;
  endtask

  // cycles counted from the start-sampling edge, the DONE cycle included
  task automatic wait_done(output int c);
    c = 1;
    while (!done && c < 1000) begin
      @(negedge clock);
      c++;
    end
    chk("done_within_budget", done, 1);
  endtask

  initial begin
    clear_grid();
    repeat (2) @(negedge clock);
    chk("reset_outputs", {busy, done, found, mem_rd, mem_addr, best_dist, best_x, best_y, raio_atual}, 0);
    reset = 1'b0;

    // 1: single target at (3,7), ring 2, dist 4; (5+7)+1 = 13 cycles
    put(3, 7, 2'd3);
    do_start(8'd5, 8'd5, 2'b00);
    wait_done(cyc);
    chk("t1_cycles", cyc, 13);
    chk("t1_found", found, 1);
    chk("t1_best_x", best_x, 3);
    chk("t1_best_y", best_y, 7);
    chk("t1_dist", best_dist, 4);
    chk("t1_raio", raio_atual, 2);
    chk("t1_reads", rd_count - rd_base, 8);
`ifdef BUSCA_ESTATISTICA_EN
    chk("t1_celulas_lidas", celulas_lidas, 8);
`endif
    @(negedge clock);
    chk("t1_done_pulse", done, 0);
    chk("t1_found_held", found, 1);

    // 2: tie at dist 3, (4,7) comes before (3,6) in scan order
    clear_grid();
    put(4, 7, 2'd3);
    put(3, 6, 2'd3);
    put(5, 5, 2'd3);  // origin is never read
    do_start(8'd5, 8'd5, 2'b00);
    wait_done(cyc);
    chk("t2_cycles", cyc, 13);
    chk("t2_best_x", best_x, 4);
    chk("t2_best_y", best_y, 7);
    chk("t2_dist", best_dist, 3);

    // 3: corner, ring 1 entirely outside: 5 cycles + DONE, no reads
    clear_grid();
    do_start(8'd0, 8'd19, 2'b00);
    wait_done(cyc);
    chk("t3_cycles", cyc, 6);
    chk("t3_found", found, 0);
    chk("t3_reads", rd_count - rd_base, 0);
    chk("t3_raio", raio_atual, 1);

    // 4: empty grid, x+ y- from (10,10): ring 11 is the first fully outside
    //    (y=-1 row, x=21 column); sum r=1..11 of (2r+3) = 165, +1 DONE
    do_start(8'd10, 8'd10, 2'b11);
    wait_done(cyc);
    chk("t4_cycles", cyc, 166);
    chk("t4_found", found, 0);
    chk("t4_raio", raio_atual, 11);
    chk("t4_addr_range", bad_addr, 0);

    // 5: abort in ring 3, then a fresh search
    do_start(8'd10, 8'd10, 2'b00);
    cyc = 0;
    while (raio_atual != 8'd3 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    chk("t5_reached_ring3", raio_atual, 3);
    abort = 1'b1;
    #1;
    chk("t5_abort_no_rd", mem_rd, 0);
    ds = done_seen;
    @(negedge clock);
    abort = 1'b0;
    chk("t5_busy_after_abort", busy, 0);
    repeat (5) @(negedge clock);
    #1;
    chk("t5_no_done", done_seen - ds, 0);
    put(3, 3, 2'd3);
    do_start(8'd2, 8'd2, 2'b01);
    wait_done(cyc);
    chk("t5_cycles", cyc, 6);
    chk("t5_found", found, 1);
    chk("t5_dist", best_dist, 2);
    chk("t5_best_xy", {best_x, best_y}, {8'd3, 8'd3});

    // 6: reset mid-search clears everything at once
    clear_grid();
    put(3, 7, 2'd3);
    do_start(8'd5, 8'd5, 2'b00);
    repeat (2) @(negedge clock);
    chk("t6_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_reset_outputs", {busy, done, found, mem_rd, mem_addr, best_dist, best_x, best_y, raio_atual}, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t6_idle_after", {busy, done}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
